// File: rtl/uop_queue.sv
// Decoder-to-backend uop FIFO: circular buffer with an occupancy counter,
// a ROB-full stall on issue, and a flush that drops every queued uop.
module uop_queue #(
  parameter int NUM_UOPS      = 32,
  parameter int XLEN          = 32,
  parameter int ARCHFILE_SIZE = 32,
  parameter int DEPTH         = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             dec_valid,
  output logic                             dec_ready,
  input  logic [$clog2(NUM_UOPS)-1:0]      dec_uop,
  input  logic                             dec_eoi,
  input  logic [XLEN-1:0]                  dec_imm,
  input  logic                             dec_use_imm,
  input  logic [31:0]                      dec_pc,
  input  logic                             dec_except,
  input  logic [$clog2(ARCHFILE_SIZE)-1:0] dec_src1_arch,
  input  logic [$clog2(ARCHFILE_SIZE)-1:0] dec_src2_arch,
  input  logic [$clog2(ARCHFILE_SIZE)-1:0] dec_dest_arch,
  input  logic                             rob_full,
  input  logic                             flush,
  output logic                             uop_ready,
  output logic [$clog2(NUM_UOPS)-1:0]      uop,
  output logic                             eoi,
  output logic [XLEN-1:0]                  imm,
  output logic                             use_imm,
  output logic [31:0]                      pc,
  output logic                             except,
  output logic [$clog2(ARCHFILE_SIZE)-1:0] src1_arch,
  output logic [$clog2(ARCHFILE_SIZE)-1:0] src2_arch,
  output logic [$clog2(ARCHFILE_SIZE)-1:0] dest_arch,
  output logic [$clog2(DEPTH):0]           count,
  output logic [$clog2(DEPTH):0]           instr_pending
);

  localparam int UW    = $clog2(NUM_UOPS);
  localparam int RW    = $clog2(ARCHFILE_SIZE);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [UW-1:0]   uop;
    logic            eoi;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic [31:0]     pc;
    logic            except;
    logic [RW-1:0]   src1_arch;
    logic [RW-1:0]   src2_arch;
    logic [RW-1:0]   dest_arch;
  } entry_t;

  // Handshake: the decoder's uop moves into the queue on any edge where
  // dec_valid & dec_ready & ~flush; the backend takes the head on any cycle
  // uop_ready=1 (no ack from the backend side).

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic             push, pop;
  entry_t           head_entry;

  assign dec_ready  = (count != CNT_W'(DEPTH)) & ~rst;
  assign uop_ready  = (count != '0) & ~rob_full & ~flush;
  assign push       = dec_valid & dec_ready & ~flush;
  assign pop        = uop_ready;
  assign head_entry = mem[head];

  assign uop       = head_entry.uop;
  assign eoi       = head_entry.eoi;
  assign imm       = head_entry.imm;
  assign use_imm   = head_entry.use_imm;
  assign pc        = head_entry.pc;
  assign except    = head_entry.except;
  assign src1_arch = head_entry.src1_arch;
  assign src2_arch = head_entry.src2_arch;
  assign dest_arch = head_entry.dest_arch;

  // Storage is deliberately left out of reset; push is already low during rst.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{uop: dec_uop, eoi: dec_eoi, imm: dec_imm,
                     use_imm: dec_use_imm, pc: dec_pc, except: dec_except,
                     src1_arch: dec_src1_arch, src2_arch: dec_src2_arch,
                     dest_arch: dec_dest_arch};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      instr_pending <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({push & dec_eoi, pop & head_entry.eoi})
        2'b10:   instr_pending <= instr_pending + 1'b1;
        2'b01:   instr_pending <= instr_pending - 1'b1;
        default: instr_pending <= instr_pending;
      endcase
    end
  end

endmodule

// File: tb/tb_uop_queue.sv
// Directed bench for uop_queue: inputs change 1 ns after each rising edge,
// outputs are sampled 1 ns later, well clear of the next edge.
module tb_uop_queue;

  logic        clk = 1'b0;
  logic        rst, dec_valid, dec_ready, dec_eoi, dec_use_imm, dec_except;
  logic [4:0]  dec_uop, dec_src1_arch, dec_src2_arch, dec_dest_arch;
  logic [31:0] dec_imm, dec_pc;
  logic        rob_full, flush, uop_ready, eoi, use_imm, except;
  logic [4:0]  uop, src1_arch, src2_arch, dest_arch;
  logic [31:0] imm, pc;
  logic [3:0]  count, instr_pending;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  uop_queue dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_uop(dec_uop), .dec_eoi(dec_eoi), .dec_imm(dec_imm),
    .dec_use_imm(dec_use_imm), .dec_pc(dec_pc), .dec_except(dec_except),
    .dec_src1_arch(dec_src1_arch), .dec_src2_arch(dec_src2_arch),
    .dec_dest_arch(dec_dest_arch), .rob_full(rob_full), .flush(flush),
    .uop_ready(uop_ready), .uop(uop), .eoi(eoi), .imm(imm), .use_imm(use_imm),
    .pc(pc), .except(except), .src1_arch(src1_arch), .src2_arch(src2_arch),
    .dest_arch(dest_arch), .count(count), .instr_pending(instr_pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [4:0] u, input logic [31:0] p, input logic e);
    dec_valid     = 1'b1;
    dec_uop       = u;
    dec_pc        = p;
    dec_eoi       = e;
    dec_imm       = p ^ 32'hA5A5_0000;
    dec_use_imm   = p[2];
    dec_except    = 1'b0;
    dec_src1_arch = u;
    dec_src2_arch = u + 5'd1;
    dec_dest_arch = u + 5'd2;
  endtask

  initial begin
    rst = 1'b1; dec_valid = 1'b0; rob_full = 1'b0; flush = 1'b0;
    offer(5'd0, 32'd0, 1'b0);
    dec_valid = 1'b0;
    step(); step();
    check("rst_dec_ready", dec_ready, 0);
    rst = 1'b0;
    settle();
    check("reset_dec_ready", dec_ready, 1);
    check("reset_uop_ready", uop_ready, 0);
    check("reset_count", count, 0);
    check("reset_instr_pending", instr_pending, 0);

    // Single uop: issues exactly one cycle after its push edge.
    offer(5'h0A, 32'h100, 1'b1);
    settle();
    check("t1_empty_no_issue", uop_ready, 0);
    step();
    dec_valid = 1'b0;
    settle();
    check("t1_uop_ready", uop_ready, 1);
    check("t1_uop", uop, 5'h0A);
    check("t1_pc", pc, 32'h100);
    check("t1_count1", count, 1);
    check("t1_ip1", instr_pending, 1);
    step();
    check("t1_count0", count, 0);
    check("t1_ip0", instr_pending, 0);
    check("t1_drained", uop_ready, 0);

    // Fill under rob_full; eoi on odd entries (pc 4,12,20,28).
    rob_full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(5'(i), 32'(4 * i), 1'(i % 2));
      exp_q.push_back(32'(4 * i));
      step();
    end
    dec_valid = 1'b0;
    settle();
    check("t2_full_dec_ready", dec_ready, 0);
    check("t2_full_count", count, 8);
    check("t2_full_ip", instr_pending, 4);
    check("t2_stalled", uop_ready, 0);

    // Full queue: an offered uop is refused even while the head issues.
    offer(5'h1F, 32'h999, 1'b1);
    rob_full = 1'b0;
    settle();
    check("t3_dec_ready", dec_ready, 0);
    check("t3_uop_ready", uop_ready, 1);
    exp_pc = exp_q.pop_front();
    check("t3_head_pc", pc, exp_pc);
    step();
    dec_valid = 1'b0;
    settle();
    check("t3_count7", count, 7);
    check("t3_dec_ready_after_pop", dec_ready, 1);
    for (int i = 1; i < 8; i++) begin
      check("t2_issue_valid", uop_ready, 1);
      exp_pc = exp_q.pop_front();
      check("t2_issue_pc", pc, exp_pc);
      step();
    end
    check("t2_drain_count", count, 0);
    check("t2_drain_ip", instr_pending, 0);
    check("t2_drain_uop_ready", uop_ready, 0);

    // Streaming one push and one pop per cycle across pointer wrap.
    offer(5'd1, 32'h1000, 1'b0);
    exp_q.push_back(32'h1000);
    step();
    for (int k = 1; k < 20; k++) begin
      offer(5'(k), 32'h1000 + 32'(4 * k), 1'b0);
      exp_q.push_back(32'h1000 + 32'(4 * k));
      settle();
      check("t4_count1", count, 1);
      check("t4_uop_ready", uop_ready, 1);
      exp_pc = exp_q.pop_front();
      check("t4_pc", pc, exp_pc);
      step();
    end
    dec_valid = 1'b0;
    settle();
    exp_pc = exp_q.pop_front();
    check("t4_last_pc", pc, exp_pc);
    step();
    check("t4_end_count", count, 0);

    // Flush with 5 queued (eoi 0,1,0,0,1) and a uop on offer.
    rob_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(5'(i), 32'h3000 + 32'(4 * i), 1'(i == 1 || i == 4));
      step();
    end
    dec_valid = 1'b0;
    settle();
    check("t5_count5", count, 5);
    check("t5_ip2", instr_pending, 2);
    offer(5'h11, 32'h3FFC, 1'b1);
    flush = 1'b1;
    rob_full = 1'b0;
    settle();
    check("t5_flush_no_issue", uop_ready, 0);
    step();
    flush = 1'b0;
    dec_valid = 1'b0;
    settle();
    check("t5_count0", count, 0);
    check("t5_ip0", instr_pending, 0);
    check("t5_uop_ready", uop_ready, 0);

    // Reset mid-stream, then a fresh push issues one cycle later.
    rob_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(5'(i), 32'h4000 + 32'(4 * i), 1'b1);
      step();
    end
    dec_valid = 1'b0;
    rob_full = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("t6_uop_ready", uop_ready, 0);
    check("t6_count", count, 0);
    check("t6_ip", instr_pending, 0);
    offer(5'h07, 32'h2000, 1'b1);
    settle();
    check("t6_same_cycle_no_issue", uop_ready, 0);
    step();
    dec_valid = 1'b0;
    settle();
    check("t6_issue", uop_ready, 1);
    check("t6_pc", pc, 32'h2000);
    check("t6_uop", uop, 5'h07);
    check("t6_imm", imm, 32'h2000 ^ 32'hA5A5_0000);
    check("t6_dest_arch", dest_arch, 5'h09);
    step();
    check("t6_count_end", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uop_queue.md
Name: uop_queue

Overview:
- Decoupling FIFO between the decoder and the backend rename/dispatch stage. It is the transmitter for the backend uop interface (uop_ready, uop, eoi, imm, use_imm, pc, except, src1_arch, src2_arch, dest_arch).
- Accepts decoded uops with a valid/ready handshake and presents them in order to the backend, one per cycle.
- Issue is withheld while the backend reports ROB full. A flush discards all queued uops.

Parameters:
NUM_UOPS, 32, number of distinct uop encodings; uop width is $clog2(NUM_UOPS)
XLEN, 32, immediate width
ARCHFILE_SIZE, 32, architectural registers; reg index width is $clog2(ARCHFILE_SIZE)
DEPTH, 8, queue entries; must be a power of 2 and at least 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dec_valid  in  1  decoder offers a uop
dec_ready  out  1  queue can accept; equals (count != DEPTH)
dec_uop  in  $clog2(NUM_UOPS)  uop encoding
dec_eoi  in  1  last uop of its instruction
dec_imm  in  XLEN  immediate
dec_use_imm  in  1  use immediate as op2
dec_pc  in  32  instruction PC
dec_except  in  1  decode exception flag
dec_src1_arch, dec_src2_arch, dec_dest_arch  in  $clog2(ARCHFILE_SIZE) each  arch register indices
rob_full  in  1  backend stall
flush  in  1  discard all queued uops
uop_ready  out  1  head uop is valid and issued this cycle
uop, eoi, imm, use_imm, pc, except, src1_arch, src2_arch, dest_arch  out  as the dec_* inputs  head entry fields
count  out  $clog2(DEPTH)+1  occupancy
instr_pending  out  $clog2(DEPTH)+1  number of queued entries with eoi=1

Behaviour:
- Storage: circular buffer with head/tail pointers of width $clog2(DEPTH). Pointers wrap modulo DEPTH. Occupancy is tracked by count, not by pointer compare.
- push = dec_valid & dec_ready & ~flush.
- pop = uop_ready = (count != 0) & ~rob_full & ~flush. uop_ready is combinational from state and inputs. The backend consumes the uop on any cycle where uop_ready=1; there is no backend-side ack.
- Data outputs always show the head entry. When count==0 they hold the last-written content and the backend must treat them as don't-care.
- Latency: a uop pushed at edge N can issue in the cycle after edge N (minimum one cycle; no bypass).
- count update on each edge: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Full queue (count==DEPTH): dec_ready=0 even when a pop occurs that cycle. No full-cycle bypass.
- Empty queue (count==0): uop_ready=0. A simultaneous push is accepted normally.
- instr_pending: +1 when a pushed entry has eoi=1, -1 when a popped entry has eoi=1, net 0 when both happen on the same edge.
- rob_full=1: head is held, uop_ready=0, and pushes continue until the queue is full.
- flush=1 at an edge: head, tail, count and instr_pending all go to 0. No push and no pop that cycle. Flush takes priority over dec_valid and any issue.
- rst=1 at an edge: same state result as flush. During rst, dec_ready is 0.
- Reset values: uop_ready=0, dec_ready=1 (after reset deasserts), count=0, instr_pending=0. Storage contents are not reset; data outputs are therefore X/don't-care until the first push.
- Reset asserted mid-stream drops all entries. The first uop after reset issues at the earliest one cycle after its push.
- except is carried unmodified. The queue takes no action on it.

Test Plan:
- Reset, then push one uop (uop=5'h0A, pc=32'h100, eoi=1) -> uop_ready=1 exactly one cycle later with uop=0A, pc=100; count goes 1 then 0; instr_pending goes 1 then 0.
- With rob_full=1, push 8 uops with pc=0,4,…,28 -> dec_ready=0 after the 8th push and count=8. Release rob_full -> 8 consecutive issues in pc order 0..28, and dec_ready=1 after the first pop edge.
- Full queue, dec_valid=1 and pop in the same cycle -> dec_ready=0 and the push is not taken; count goes 8 to 7.
- Continuous push and pop at one per cycle for 20 uops -> count stays at 1, pointers wrap past DEPTH, issued pc sequence is correct with no gaps.
- 5 entries queued (eoi pattern 0,1,0,0,1), assert flush together with dec_valid=1 -> next cycle count=0, instr_pending=0, uop_ready=0, and the offered uop is dropped.
- Assert rst with 3 entries queued and rob_full=0 -> next cycle uop_ready=0 and count=0. A push after rst deasserts issues one cycle later.
